i2c_initiator_engine: RTL and testbench

- Initiator end of the team's single-byte I2C link; the counterpart of the target-side pattern detector.
- Accepts one transaction request: START, 7-bit address plus R/W bit, target ACK sample, one data byte (written or read), STOP.
- Generates SCL from the system clock. Drives SDA open-drain style.
- Returns read data, completion and ACK-error status to the local controller.

---
 rtl/i2c_initiator_engine.sv | 218 +++++++++++++++++++++
 tb/tb_i2c_initiator_engine.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_initiator_engine.sv
`default_nettype none
// ============================================================================
// Module   : i2c_initiator_engine
// Purpose  : Single-byte I2C initiator. One request produces START, address
//            byte {addr, rw}, address ACK sample, one data byte (written or
//            read, read answered with NACK), then STOP. SCL is generated from
//            clk: one bit slot = 4 quarters of CLK_DIV clocks each. SCL and SDA
//            are open-drain style (1 = release, 0 = drive low).
// Optional : `define CLOCK_STRETCH_EN lets a target hold SCL low; the divider
//            and quarter counters freeze in q1/q2 while SCL_out=1, SCL_in=0.
// Ports    : clk, rst_n (async, active low)
//            start_req/rw/target_addr/controller_data_req : request (IDLE only)
//            SDA_in, SCL_in                               : resolved bus lines
//            SCL_out, SDA_out                             : bus drive
//            busy, done, ack_error, controller_data_rsp, rd_valid : status
// Revision : 1.0 - initial release
// ============================================================================
module i2c_initiator_engine #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 7,
   parameter int CLK_DIV       = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start_req,
   input  logic                     rw,
   input  logic [ADDRESS_WIDTH-1:0] target_addr,
   input  logic [DATA_WIDTH-1:0]    controller_data_req,
   input  logic                     SDA_in,
   input  logic                     SCL_in,
   output logic                     SCL_out,
   output logic                     SDA_out,
   output logic                     busy,
   output logic                     done,
   output logic                     ack_error,
   output logic [DATA_WIDTH-1:0]    controller_data_rsp,
   output logic                     rd_valid
);

   localparam int AB_W  = ADDRESS_WIDTH + 1;
   localparam int MAX_W = (DATA_WIDTH > AB_W) ? DATA_WIDTH : AB_W;
   localparam int BIT_W = $clog2(MAX_W);
   localparam int DIV_W = $clog2(CLK_DIV);

   localparam logic [BIT_W-1:0] c_addr_last = BIT_W'(AB_W - 1);
   localparam logic [BIT_W-1:0] c_data_last = BIT_W'(DATA_WIDTH - 1);
   localparam logic [DIV_W-1:0] c_div_last  = DIV_W'(CLK_DIV - 1);

   typedef enum logic [3:0] {
      ST_IDLE, ST_START, ST_ADDR, ST_ADDR_ACK, ST_WRITE,
      ST_WRITE_ACK, ST_READ, ST_READ_NACK, ST_STOP
   } state_t;

   state_t                 r_state;
   logic [1:0]             r_q;
   logic [DIV_W-1:0]       r_div;
   logic [BIT_W-1:0]       r_bit;
   logic [AB_W-1:0]        r_addr_byte;
   logic [DATA_WIDTH-1:0]  r_wdata;
   logic [DATA_WIDTH-1:0]  r_shift;
   logic                   r_rw;
   logic                   r_sample;

   state_t                 w_nxt_state;
   logic [1:0]             w_nxt_q;
   logic [DIV_W-1:0]       w_nxt_div;
   logic [BIT_W-1:0]       w_nxt_bit;
   logic                   w_nxt_scl;
   logic                   w_nxt_sda;
   logic [AB_W-1:0]        w_addr_sh;
   logic [DATA_WIDTH-1:0]  w_data_sh;
   logic                   w_freeze;
   logic                   w_tick;
   logic                   w_sample;
   logic                   w_slot_end;

`ifdef CLOCK_STRETCH_EN
   // Only the SCL-high quarters can be stretched: a target can only hold
   // the line low once we have released it.
   assign w_freeze = ((r_q == 2'd1) || (r_q == 2'd2)) && SCL_out && !SCL_in;
`else
   logic w_unused_scl_in;
   assign w_unused_scl_in = SCL_in;
   assign w_freeze        = 1'b0;
`endif

   // w_tick marks the last clock of a quarter
   assign w_tick     = (r_state != ST_IDLE) && !w_freeze && (r_div == c_div_last);
   assign w_sample   = w_tick && (r_q == 2'd1);
   assign w_slot_end = w_tick && (r_q == 2'd3);

   // Next-state / counter logic; bus lines are registered from these values
   // so SCL/SDA change in the same cycle the quarter or state changes.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_q     = r_q;
      w_nxt_div   = r_div;
      w_nxt_bit   = r_bit;
      if (r_state == ST_IDLE) begin
         if (start_req) w_nxt_state = ST_START;
      end else if (!w_freeze) begin
         if (r_div == c_div_last) begin
            w_nxt_div = '0;
            w_nxt_q   = r_q + 2'd1;
            if (r_q == 2'd3) begin
               case (r_state)
                  ST_START:     w_nxt_state = ST_ADDR;
                  ST_ADDR:      if (r_bit == c_addr_last) w_nxt_state = ST_ADDR_ACK;
                                else w_nxt_bit = r_bit + BIT_W'(1);
                  ST_ADDR_ACK:  if (r_sample)  w_nxt_state = ST_STOP;
                                else if (r_rw) w_nxt_state = ST_READ;
                                else           w_nxt_state = ST_WRITE;
                  ST_WRITE:     if (r_bit == c_data_last) w_nxt_state = ST_WRITE_ACK;
                                else w_nxt_bit = r_bit + BIT_W'(1);
                  ST_WRITE_ACK: w_nxt_state = ST_STOP;
                  ST_READ:      if (r_bit == c_data_last) w_nxt_state = ST_READ_NACK;
                                else w_nxt_bit = r_bit + BIT_W'(1);
                  ST_READ_NACK: w_nxt_state = ST_STOP;
                  default:      w_nxt_state = ST_IDLE;
               endcase
               if (w_nxt_state != r_state) w_nxt_bit = '0;
            end
         end else begin
            w_nxt_div = r_div + DIV_W'(1);
         end
      end

      // Line decode for the upcoming cycle. MSB-first transmit via shift.
      w_addr_sh = r_addr_byte << w_nxt_bit;
      w_data_sh = r_wdata << w_nxt_bit;
      w_nxt_scl = 1'b1;
      w_nxt_sda = 1'b1;
      case (w_nxt_state)
         ST_START: begin
            w_nxt_scl = 1'b1;
            w_nxt_sda = ~w_nxt_q[1];             // SDA falls at q2: START
         end
         ST_ADDR: begin
            w_nxt_scl = w_nxt_q[0] ^ w_nxt_q[1];
            w_nxt_sda = w_addr_sh[AB_W-1];
         end
         ST_WRITE: begin
            w_nxt_scl = w_nxt_q[0] ^ w_nxt_q[1];
            w_nxt_sda = w_data_sh[DATA_WIDTH-1];
         end
         ST_ADDR_ACK, ST_WRITE_ACK, ST_READ, ST_READ_NACK: begin
            w_nxt_scl = w_nxt_q[0] ^ w_nxt_q[1];
            w_nxt_sda = 1'b1;
         end
         ST_STOP: begin
            w_nxt_scl = (w_nxt_q != 2'd0);
            w_nxt_sda = w_nxt_q[1];              // SDA rises at q2: STOP
         end
         default: begin
            w_nxt_scl = 1'b1;
            w_nxt_sda = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state             <= ST_IDLE;
         r_q                 <= '0;
         r_div               <= '0;
         r_bit               <= '0;
         r_addr_byte         <= '0;
         r_wdata             <= '0;
         r_shift             <= '0;
         r_rw                <= 1'b0;
         r_sample            <= 1'b1;
         SCL_out             <= 1'b1;
         SDA_out             <= 1'b1;
         busy                <= 1'b0;
         done                <= 1'b0;
         ack_error           <= 1'b0;
         controller_data_rsp <= '0;
         rd_valid            <= 1'b0;
      end else begin
         r_state  <= w_nxt_state;
         r_q      <= w_nxt_q;
         r_div    <= w_nxt_div;
         r_bit    <= w_nxt_bit;
         SCL_out  <= w_nxt_scl;
         SDA_out  <= w_nxt_sda;
         done     <= 1'b0;
         rd_valid <= 1'b0;

         if ((r_state == ST_IDLE) && start_req) begin
            r_addr_byte <= {target_addr, rw};
            r_rw        <= rw;
            r_wdata     <= controller_data_req;
            ack_error   <= 1'b0;
            busy        <= 1'b1;
         end

         if (w_sample) begin
            r_sample <= SDA_in;
            if (r_state == ST_READ) r_shift <= {r_shift[DATA_WIDTH-2:0], SDA_in};
         end

         if (w_slot_end) begin
            case (r_state)
               ST_ADDR_ACK: if (r_sample) ack_error <= 1'b1;
               ST_READ:     if (r_bit == c_data_last) controller_data_rsp <= r_shift;
               ST_STOP: begin
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  rd_valid <= r_rw & ~ack_error;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_i2c_initiator_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_initiator_engine
// Purpose  : Directed self-checking bench for i2c_initiator_engine (CLK_DIV=4).
//            A bus monitor records SDA_out at every SCL rise; a target model
//            answers on SDA according to the slot index (count of SCL falls).
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_initiator_engine;

   localparam int CLK_DIV = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_req = 1'b0;
   logic       rw = 1'b0;
   logic [6:0] target_addr = '0;
   logic [7:0] controller_data_req = '0;
   logic       SDA_in, SCL_in;
   logic       SCL_out, SDA_out, busy, done, ack_error, rd_valid;
   logic [7:0] controller_data_rsp;

   int n_pass = 0;
   int n_total = 0;

   // target model controls (written by the stimulus process only)
   int         tgt_mode = 0;       // 0 = ACK write, 1 = read, 2 = NACK all
   logic [7:0] tgt_rd = '0;
   logic       tgt_scl = 1'b1;
   logic       clr_req = 1'b0;

   // monitor state (written by the monitor process only)
   logic       clr_seen = 1'b0;
   logic [0:63] rbits;
   int         rise_cnt = 0, fall_cnt = 0, done_cnt = 0, hl_chg = 0;
   int         hi_len = 0, hi_min = 1000, hi_max = 0;
   logic       prev_scl = 1'b1, prev_sda = 1'b1;

   function automatic logic tgt_f(input int mode, input int n, input logic [7:0] rd);
      if (mode == 0) return !((n == 9) || (n == 18));
      if (mode == 1) begin
         if (n == 9) return 1'b0;
         if ((n >= 10) && (n <= 17)) return rd[17 - n];
      end
      return 1'b1;
   endfunction

   function automatic logic [7:0] bits_byte(input int start);
      logic [7:0] b;
      b = '0;
      for (int i = 0; i < 8; i++) b = {b[6:0], rbits[start + i]};
      return b;
   endfunction

   assign SDA_in = SDA_out & tgt_f(tgt_mode, fall_cnt, tgt_rd);
   assign SCL_in = SCL_out & tgt_scl;

   i2c_initiator_engine #(.DATA_WIDTH(8), .ADDRESS_WIDTH(7), .CLK_DIV(CLK_DIV)) dut (
      .clk(clk), .rst_n(rst_n), .start_req(start_req), .rw(rw),
      .target_addr(target_addr), .controller_data_req(controller_data_req),
      .SDA_in(SDA_in), .SCL_in(SCL_in), .SCL_out(SCL_out), .SDA_out(SDA_out),
      .busy(busy), .done(done), .ack_error(ack_error),
      .controller_data_rsp(controller_data_rsp), .rd_valid(rd_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // bus monitor
   always @(negedge clk) begin
      if (clr_req != clr_seen) begin
         clr_seen = clr_req;
         rbits = '0; rise_cnt = 0; fall_cnt = 0; done_cnt = 0; hl_chg = 0;
         hi_len = 0; hi_min = 1000; hi_max = 0;
      end else begin
         if (done) done_cnt++;
         if (!prev_scl && SCL_out) begin
            if (rise_cnt < 64) rbits[rise_cnt] = SDA_out;
            rise_cnt++;
            hi_len = 1;
         end else if (prev_scl && SCL_out) begin
            hi_len++;
            if (SDA_out != prev_sda) hl_chg++;
         end
         if (prev_scl && !SCL_out) begin
            fall_cnt++;
            if (fall_cnt >= 2) begin
               if (hi_len < hi_min) hi_min = hi_len;
               if (hi_len > hi_max) hi_max = hi_len;
            end
         end
      end
      prev_scl = SCL_out;
      prev_sda = SDA_out;
   end

   // One transaction; returns observations, no checking here.
   task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] d,
                          input int mode, input logic [7:0] rdat, input int inj_cyc,
                          input int str_rise, output int cyc, output logic busy_s,
                          output logic rdv, output logic aerr, output logic busy_end,
                          output logic done_after, output logic scl_hold);
      int str_left;
      logic str_done;
      tgt_mode = mode; tgt_rd = rdat; tgt_scl = 1'b1;
      clr_req = ~clr_req;
      @(negedge clk); #1;
      target_addr = a; rw = r; controller_data_req = d; start_req = 1'b1;
      @(posedge clk); #1;
      start_req = 1'b0;
      cyc = 0; str_left = 0; str_done = 1'b0; scl_hold = 1'b1;
      @(negedge clk); #1;
      busy_s = busy;
      while (!done && (cyc < 3000)) begin
         @(posedge clk); cyc++;
         @(negedge clk); #1;
         if (cyc == inj_cyc) begin
            target_addr = 7'h55; rw = 1'b1; start_req = 1'b1;
         end else begin
            start_req = 1'b0;
         end
         if ((str_rise > 0) && !str_done && (rise_cnt == str_rise)) begin
            tgt_scl = 1'b0; str_left = 20; str_done = 1'b1;
         end else if (str_left > 0) begin
            str_left--;
            if (str_left == 0) begin
               scl_hold = SCL_out;
               tgt_scl = 1'b1;
            end
         end
      end
      rdv = rd_valid; aerr = ack_error; busy_end = busy;
      @(negedge clk); #1;
      done_after = done;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_total++; if (SCL_out !== 1'b1) $display("FAIL rst_scl: got %b exp 1", SCL_out); else n_pass++;
      n_total++; if (SDA_out !== 1'b1) $display("FAIL rst_sda: got %b exp 1", SDA_out); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy); else n_pass++;
      n_total++; if (done !== 1'b0) $display("FAIL rst_done: got %b exp 0", done); else n_pass++;
      n_total++; if (ack_error !== 1'b0) $display("FAIL rst_ackerr: got %b exp 0", ack_error); else n_pass++;
      n_total++; if (controller_data_rsp !== 8'h00) $display("FAIL rst_rsp: got %h exp 00", controller_data_rsp); else n_pass++;
      n_total++; if (rd_valid !== 1'b0) $display("FAIL rst_rdv: got %b exp 0", rd_valid); else n_pass++;
      @(negedge clk); rst_n = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      n_total++; if ({busy, SCL_out, SDA_out} !== 3'b011) $display("FAIL idle_lines: got %b exp 011", {busy, SCL_out, SDA_out}); else n_pass++;
   endtask

   task automatic test_write;
      int cyc; logic bs, rdv, aerr, be, da, sh;
      run_txn(7'h10, 1'b0, 8'hA5, 0, 8'h00, -1, 0, cyc, bs, rdv, aerr, be, da, sh);
      n_total++; if (bs !== 1'b1) $display("FAIL wr_busy: got %b exp 1", bs); else n_pass++;
      n_total++; if (cyc !== 320) $display("FAIL wr_latency: got %0d exp 320", cyc); else n_pass++;
      n_total++; if (bits_byte(0) !== 8'h20) $display("FAIL wr_addr_byte: got %h exp 20", bits_byte(0)); else n_pass++;
      n_total++; if (bits_byte(9) !== 8'hA5) $display("FAIL wr_data_byte: got %h exp a5", bits_byte(9)); else n_pass++;
      n_total++; if ({rbits[8], rbits[17], rbits[18]} !== 3'b110) $display("FAIL wr_ack_stop_sda: got %b exp 110", {rbits[8], rbits[17], rbits[18]}); else n_pass++;
      n_total++; if (rise_cnt !== 19) $display("FAIL wr_rises: got %0d exp 19", rise_cnt); else n_pass++;
      n_total++; if ({rdv, aerr, be} !== 3'b000) $display("FAIL wr_status: got %b exp 000", {rdv, aerr, be}); else n_pass++;
      n_total++; if (da !== 1'b0) $display("FAIL wr_done_pulse: got %b exp 0", da); else n_pass++;
      n_total++; if (hl_chg !== 2) $display("FAIL wr_sda_while_scl_high: got %0d exp 2", hl_chg); else n_pass++;
      n_total++; if ((hi_min !== 2*CLK_DIV) || (hi_max !== 2*CLK_DIV)) $display("FAIL wr_scl_high_len: got %0d..%0d exp 8", hi_min, hi_max); else n_pass++;
      n_total++; if (done_cnt !== 1) $display("FAIL wr_done_count: got %0d exp 1", done_cnt); else n_pass++;
   endtask

   task automatic test_read;
      int cyc; logic bs, rdv, aerr, be, da, sh;
      run_txn(7'h10, 1'b1, 8'h00, 1, 8'h3C, -1, 0, cyc, bs, rdv, aerr, be, da, sh);
      n_total++; if (cyc !== 320) $display("FAIL rd_latency: got %0d exp 320", cyc); else n_pass++;
      n_total++; if (bits_byte(0) !== 8'h21) $display("FAIL rd_addr_byte: got %h exp 21", bits_byte(0)); else n_pass++;
      n_total++; if (bits_byte(9) !== 8'hFF) $display("FAIL rd_sda_released: got %h exp ff", bits_byte(9)); else n_pass++;
      n_total++; if (rbits[17] !== 1'b1) $display("FAIL rd_nack_slot: got %b exp 1", rbits[17]); else n_pass++;
      n_total++; if (controller_data_rsp !== 8'h3C) $display("FAIL rd_data: got %h exp 3c", controller_data_rsp); else n_pass++;
      n_total++; if ({rdv, aerr} !== 2'b10) $display("FAIL rd_valid_with_done: got %b exp 10", {rdv, aerr}); else n_pass++;
      n_total++; if (rd_valid !== 1'b0) $display("FAIL rd_valid_pulse: got %b exp 0", rd_valid); else n_pass++;
   endtask

   task automatic test_addr_nack;
      int cyc; logic bs, rdv, aerr, be, da, sh;
      run_txn(7'h22, 1'b0, 8'h99, 2, 8'h00, -1, 0, cyc, bs, rdv, aerr, be, da, sh);
      n_total++; if (cyc !== 176) $display("FAIL nack_latency: got %0d exp 176", cyc); else n_pass++;
      n_total++; if (bits_byte(0) !== 8'h44) $display("FAIL nack_addr_byte: got %h exp 44", bits_byte(0)); else n_pass++;
      n_total++; if (aerr !== 1'b1) $display("FAIL nack_ackerr: got %b exp 1", aerr); else n_pass++;
      n_total++; if (rdv !== 1'b0) $display("FAIL nack_rdv: got %b exp 0", rdv); else n_pass++;
      n_total++; if ((rise_cnt !== 10) || (rbits[9] !== 1'b0)) $display("FAIL nack_stop_direct: got rises %0d sda %b exp 10 0", rise_cnt, rbits[9]); else n_pass++;
      repeat (20) @(negedge clk);
      #1;
      n_total++; if (ack_error !== 1'b1) $display("FAIL nack_ackerr_held: got %b exp 1", ack_error); else n_pass++;
   endtask

   task automatic test_busy_request;
      int cyc; logic bs, rdv, aerr, be, da, sh;
      run_txn(7'h10, 1'b0, 8'hA5, 0, 8'h00, 100, 0, cyc, bs, rdv, aerr, be, da, sh);
      n_total++; if (cyc !== 320) $display("FAIL busy_latency: got %0d exp 320", cyc); else n_pass++;
      n_total++; if ({bits_byte(0), bits_byte(9)} !== 16'h20A5) $display("FAIL busy_bytes: got %h exp 20a5", {bits_byte(0), bits_byte(9)}); else n_pass++;
      n_total++; if ({aerr, rdv} !== 2'b00) $display("FAIL busy_status: got %b exp 00", {aerr, rdv}); else n_pass++;
      repeat (100) @(negedge clk);
      #1;
      n_total++; if (done_cnt !== 1) $display("FAIL busy_done_count: got %0d exp 1", done_cnt); else n_pass++;
      n_total++; if ({busy, SCL_out} !== 2'b01) $display("FAIL busy_no_second_txn: got %b exp 01", {busy, SCL_out}); else n_pass++;
   endtask

   task automatic test_reset_mid;
      int cyc, waited; logic bs, rdv, aerr, be, da, sh;
      tgt_mode = 0;
      clr_req = ~clr_req;
      @(negedge clk); #1;
      target_addr = 7'h10; rw = 1'b0; controller_data_req = 8'hA5; start_req = 1'b1;
      @(posedge clk); #1;
      start_req = 1'b0;
      waited = 0;
      while (!((rise_cnt == 13) && !SCL_out) && (waited < 2000)) begin
         @(negedge clk); #1; waited++;
      end
      n_total++; if (waited >= 2000) $display("FAIL mid_reach_bit4: got timeout exp rise 13"); else n_pass++;
      n_total++; if ({SCL_out, SDA_out} !== 2'b00) $display("FAIL mid_pre_lines: got %b exp 00", {SCL_out, SDA_out}); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_total++; if ({SCL_out, SDA_out, busy} !== 3'b110) $display("FAIL mid_async_reset: got %b exp 110", {SCL_out, SDA_out, busy}); else n_pass++;
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      run_txn(7'h10, 1'b0, 8'h5A, 0, 8'h00, -1, 0, cyc, bs, rdv, aerr, be, da, sh);
      n_total++; if (cyc !== 320) $display("FAIL mid_after_latency: got %0d exp 320", cyc); else n_pass++;
      n_total++; if ({bits_byte(0), bits_byte(9)} !== 16'h205A) $display("FAIL mid_after_bytes: got %h exp 205a", {bits_byte(0), bits_byte(9)}); else n_pass++;
      n_total++; if (done_cnt !== 1) $display("FAIL mid_after_done_count: got %0d exp 1", done_cnt); else n_pass++;
   endtask

   task automatic test_stretch;
      int cyc; logic bs, rdv, aerr, be, da, sh;
      run_txn(7'h10, 1'b0, 8'hA5, 0, 8'h00, -1, 4, cyc, bs, rdv, aerr, be, da, sh);
      n_total++; if (cyc !== 340) $display("FAIL str_latency: got %0d exp 340", cyc); else n_pass++;
      n_total++; if (sh !== 1'b1) $display("FAIL str_scl_frozen: got %b exp 1", sh); else n_pass++;
      n_total++; if ({bits_byte(0), bits_byte(9)} !== 16'h20A5) $display("FAIL str_bytes: got %h exp 20a5", {bits_byte(0), bits_byte(9)}); else n_pass++;
   endtask

   initial begin
      test_reset;
      test_write;
      test_read;
      test_addr_nack;
      test_busy_request;
      test_reset_mid;
`ifdef CLOCK_STRETCH_EN
      test_stretch;
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
